// File: rtl/wr_rd_responder_if.sv
// Request/response bundle between the write-side requester, the responder and
// the read-side consumer.
interface wr_rd_responder_if #(
  parameter int DATA_W   = 8,
  parameter int MAX_PEND = 4
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              overflow;
  logic              rd;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic [CNT_W-1:0]  pend_cnt;

  modport master (
    output wr, wr_data,
    input  wr_ack, overflow, rd, rd_data, rd_last, busy, pend_cnt
  );

  modport slave (
    input  wr, wr_data,
    output wr_ack, overflow, rd, rd_data, rd_last, busy, pend_cnt
  );
endinterface

// File: rtl/wr_rd_responder.sv
// Responder for the wr/rd protocol: every wr rising edge is queued and answered
// in FIFO order by an RD_LEN-cycle rd burst that starts RD_DELAY edges later.
module wr_rd_responder #(
  parameter int DATA_W   = 8,
  parameter int RD_DELAY = 2,
  parameter int RD_LEN   = 2,
  parameter int MAX_PEND = 4
) (
  input logic              clk,
  input logic              rst,
  wr_rd_responder_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int DLY_W = $clog2(RD_DELAY);
  localparam int LEN_W = $clog2(RD_LEN + 1);

  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RD_DELAY - 2);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(RD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, WAIT, READ, GAP} state_t;

  state_t            state, state_nx;
  logic [DLY_W-1:0]  dly_cnt, dly_nx;
  logic [LEN_W-1:0]  len_cnt, len_nx;
  logic              rd_q, rd_nx;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_prev;
  logic              ack_q, ovf_q;

  logic [DATA_W-1:0] mem [MAX_PEND];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  cnt;

  logic req, full, push, pop;

  assign req  = bus.wr && !wr_prev;
  assign full = (cnt == CNT_FULL);
  // A full FIFO still accepts a request if the head leaves on the same edge.
  assign push = req && (!full || pop);

  always_comb begin
    state_nx = state;
    dly_nx   = dly_cnt;
    len_nx   = len_cnt;
    rd_nx    = rd_q;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (req || cnt != '0) begin
          state_nx = WAIT;
          dly_nx   = DLY_INIT;
        end
      end
      WAIT: begin
        if (dly_cnt == '0) begin
          if (cnt != '0) begin
            pop      = 1'b1;
            state_nx = READ;
            rd_nx    = 1'b1;
            len_nx   = LEN_INIT;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          dly_nx = dly_cnt - DLY_W'(1);
        end
      end
      READ: begin
        if (len_cnt == '0) begin
          state_nx = GAP;
          rd_nx    = 1'b0;
        end else begin
          len_nx = len_cnt - LEN_W'(1);
        end
      end
      GAP: begin
        if (cnt != '0) begin
          state_nx = WAIT;
          dly_nx   = DLY_INIT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dly_cnt <= '0;
      len_cnt <= '0;
      rd_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      dly_cnt <= dly_nx;
      len_cnt <= len_nx;
      rd_q    <= rd_nx;
    end
  end

  // wr_prev resets high so a wr held across reset release is not a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev   <= 1'b1;
      ack_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      rd_data_q <= '0;
    end else begin
      wr_prev <= bus.wr;
      ack_q   <= push;
      ovf_q   <= req && !push;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop) begin
        rptr      <= rptr + PTR_W'(1);
        rd_data_q <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wr_data;
  end

  assign bus.wr_ack   = ack_q;
  assign bus.overflow = ovf_q;
  assign bus.rd       = rd_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_last  = (state == READ) && (len_cnt == '0);
  assign bus.busy     = (state != IDLE);
  assign bus.pend_cnt = cnt;

  a_rd_hold: assert property (@(posedge clk) disable iff (rst)
    (RD_LEN > 1 && $rose(rd_q)) |=> rd_q);
  a_last_in_burst: assert property (@(posedge clk) disable iff (rst)
    (state == READ && len_cnt == '0) |-> rd_q);
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_FULL);
  a_ack_xor_ovf: assert property (@(posedge clk) disable iff (rst)
    !(ack_q && ovf_q));
  a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
    (state == WAIT && dly_cnt == '0) |-> cnt != '0);
endmodule

// File: tb/tb_wr_rd_responder.sv
// Bench for wr_rd_responder: two instances (2/2 and 5/3 timing) share one wr
// stream and are checked every cycle against a request-scheduling model.
module tb_wr_rd_responder;
  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] wr_data = '0;

  always #5 clk = ~clk;

  wr_rd_responder_if #(.DATA_W(8), .MAX_PEND(MAXP)) bus0 ();
  wr_rd_responder_if #(.DATA_W(8), .MAX_PEND(MAXP)) bus1 ();

  assign bus0.wr      = wr;
  assign bus0.wr_data = wr_data;
  assign bus1.wr      = wr;
  assign bus1.wr_data = wr_data;

  wr_rd_responder #(.DATA_W(8), .RD_DELAY(2), .RD_LEN(2), .MAX_PEND(MAXP)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  wr_rd_responder #(.DATA_W(8), .RD_DELAY(5), .RD_LEN(3), .MAX_PEND(MAXP)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  int checks = 0;
  int errors = 0;

  // Model: per accepted request, its push edge and decision edge D (the edge the
  // responder commits to serving it). Everything else follows arithmetically.
  int         ecount = 0;
  logic       wr_prev_m = 1'b1;
  int         push_e [2][128];
  int         d_e    [2][128];
  logic [7:0] dat    [2][128];
  int         nreq   [2] = '{0, 0};
  int         ack_e  [2] = '{-100, -100};
  int         ovf_e  [2] = '{-100, -100};

  function automatic int dly_of(input int u);
    return (u == 0) ? 2 : 5;
  endfunction

  function automatic int len_of(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      nreq[u]  = 0;
      ack_e[u] = -100;
      ovf_e[u] = -100;
    end
  endtask

  task automatic model_event(input int u, input int e, input logic [7:0] d);
    int occ;
    bit popnow;
    int g;
    int dd;
    int p;
    occ    = 0;
    popnow = 1'b0;
    for (int i = 0; i < nreq[u]; i++) begin
      p = d_e[u][i] + dly_of(u) - 1;
      if (p >= e) occ++;
      if (p == e) popnow = 1'b1;
    end
    if ((occ < MAXP || popnow) && nreq[u] < 128) begin
      if (nreq[u] == 0) begin
        dd = e;
      end else begin
        // g: edge at which the previous burst's trailing gap ends
        g  = d_e[u][nreq[u]-1] + dly_of(u) + len_of(u);
        dd = (e < g) ? g : ((e == g) ? g + 1 : e);
      end
      push_e[u][nreq[u]] = e;
      d_e[u][nreq[u]]    = dd;
      dat[u][nreq[u]]    = d;
      nreq[u]++;
      ack_e[u] = e;
    end else begin
      ovf_e[u] = e;
    end
  endtask

  task automatic expect_u(input int u, input int e,
                          output int rd, output int last, output int busy,
                          output int ack, output int ovf, output int pend,
                          output int data);
    int p;
    int dd;
    rd = 0; last = 0; busy = 0; pend = 0; data = 0;
    ack = (ack_e[u] == e) ? 1 : 0;
    ovf = (ovf_e[u] == e) ? 1 : 0;
    for (int i = 0; i < nreq[u]; i++) begin
      dd = d_e[u][i];
      p  = dd + dly_of(u) - 1;
      if (e >= p && e <= p + len_of(u) - 1) begin
        rd   = 1;
        data = int'(dat[u][i]);
        if (e == p + len_of(u) - 1) last = 1;
      end
      if (e >= dd && e <= dd + dly_of(u) + len_of(u) - 1) busy = 1;
      if (push_e[u][i] <= e && p > e) pend++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
        wr_prev_m = 1'b1;
      end else begin
        ecount++;
        if (wr && !wr_prev_m) begin
          for (int u = 0; u < 2; u++) model_event(u, ecount, wr_data);
        end
        wr_prev_m = wr;
      end
    end
  end

  initial begin
    int erd, elast, ebusy, eack, eovf, epend, edata;
    int ard, alast, abusy, aack, aovf, apend, adata;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        expect_u(u, ecount, erd, elast, ebusy, eack, eovf, epend, edata);
        if (u == 0) begin
          ard = int'(bus0.rd); alast = int'(bus0.rd_last); abusy = int'(bus0.busy);
          aack = int'(bus0.wr_ack); aovf = int'(bus0.overflow);
          apend = int'(bus0.pend_cnt); adata = int'(bus0.rd_data);
        end else begin
          ard = int'(bus1.rd); alast = int'(bus1.rd_last); abusy = int'(bus1.busy);
          aack = int'(bus1.wr_ack); aovf = int'(bus1.overflow);
          apend = int'(bus1.pend_cnt); adata = int'(bus1.rd_data);
        end
        chk($sformatf("u%0d rd", u), ard, erd);
        chk($sformatf("u%0d rd_last", u), alast, elast);
        chk($sformatf("u%0d busy", u), abusy, ebusy);
        chk($sformatf("u%0d wr_ack", u), aack, eack);
        chk($sformatf("u%0d overflow", u), aovf, eovf);
        chk($sformatf("u%0d pend_cnt", u), apend, epend);
        if (erd != 0) chk($sformatf("u%0d rd_data", u), adata, edata);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] t2 [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    chk("reset rd", int'(bus0.rd), 0);
    chk("reset pend_cnt", int'(bus0.pend_cnt), 0);
    chk("reset busy", int'(bus0.busy), 0);

    // isolated write
    wr = 1'b1; wr_data = 8'hA5;
    step(1);
    chk("t1 wr_ack", int'(bus0.wr_ack), 1);
    chk("t1 overflow", int'(bus0.overflow), 0);
    wr = 1'b0;
    step(1);
    chk("t1 rd first", int'(bus0.rd), 1);
    chk("t1 rd_data", int'(bus0.rd_data), 'hA5);
    chk("t1 rd_last first", int'(bus0.rd_last), 0);
    step(1);
    chk("t1 rd second", int'(bus0.rd), 1);
    chk("t1 rd_last second", int'(bus0.rd_last), 1);
    step(1);
    chk("t1 rd end", int'(bus0.rd), 0);
    step(12);

    // three spaced writes
    for (int k = 0; k < 3; k++) begin
      wr = 1'b1; wr_data = t2[k];
      step(1);
      wr = 1'b0;
      step(5);
    end
    step(20);

    // back-to-back writes every 2 edges: overflow on the 9th, then full+pop push
    for (int k = 0; k < 10; k++) begin
      wr = 1'b1; wr_data = 8'h40 + 8'(k);
      step(1);
      if (k == 8) begin
        chk("t3 overflow", int'(bus0.overflow), 1);
        chk("t3 no ack", int'(bus0.wr_ack), 0);
        chk("t3 pend peak", int'(bus0.pend_cnt), 4);
      end
      if (k == 9) chk("t3 ack after drop", int'(bus0.wr_ack), 1);
      wr = 1'b0;
      step(1);
    end
    step(1);
    chk("t4 pend full", int'(bus0.pend_cnt), 4);
    wr = 1'b1; wr_data = 8'hF4;
    step(1);
    chk("t4 full+pop ack", int'(bus0.wr_ack), 1);
    chk("t4 full+pop no ovf", int'(bus0.overflow), 0);
    chk("t4 pend stays", int'(bus0.pend_cnt), 4);
    wr = 1'b0;
    step(120);

    // reset in the middle of a burst, wr held high across release
    wr = 1'b1; wr_data = 8'h5A;
    step(1);
    wr = 1'b0;
    step(1);
    chk("t5 rd before rst", int'(bus0.rd), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5 rd async drop", int'(bus0.rd), 0);
    chk("t5 pend cleared", int'(bus0.pend_cnt), 0);
    chk("t5 busy cleared", int'(bus0.busy), 0);
    chk("t5 pend1 cleared", int'(bus1.pend_cnt), 0);
    wr = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    chk("t5 held wr busy", int'(bus0.busy), 0);
    chk("t5 held wr pend", int'(bus0.pend_cnt), 0);
    chk("t5 held wr ack", int'(bus0.wr_ack), 0);
    wr = 1'b0;
    step(1);
    wr = 1'b1; wr_data = 8'h77;
    step(1);
    chk("t5 new rise ack", int'(bus0.wr_ack), 1);
    wr = 1'b0;
    step(20);

    // RD_DELAY=5, RD_LEN=3 instance: rd after edges N+4..N+6
    wr = 1'b1; wr_data = 8'hC3;
    step(1);
    wr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("t6 rd k%0d", k), int'(bus1.rd), (k >= 4 && k <= 6) ? 1 : 0);
      chk($sformatf("t6 rd_last k%0d", k), int'(bus1.rd_last), (k == 6) ? 1 : 0);
      if (k == 4) chk("t6 rd_data", int'(bus1.rd_data), 'hC3);
    end
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
